// File: rtl/craft_pkg.sv
// CRAFT primitives shared by the encrypt/decrypt cores and the key register:
// S-box, nibble permutations, MixColumn, tweak permutation and round constants.
package craft_pkg;
    localparam int NR      = 32;
    localparam int CNT_W   = $clog2(NR);
    localparam int STATE_W = 64;
    localparam int TK_W    = 64;
    localparam int KEY_W   = 128;

    // Tables are packed nibble lists; entry 0 sits in the most significant nibble.
    localparam logic [63:0]  SBOX_TBL  = 64'hCAD3EBF789150246;
    localparam logic [63:0]  PN_TBL    = 64'hFCDEA98B65471230;
    localparam logic [63:0]  PNINV_TBL = 64'hFCDEA98B65471230;
    localparam logic [63:0]  Q_TBL     = 64'hCAF5E892B374601D;
    localparam logic [127:0] RC_A_TBL  = 128'h18429C6B5ADEF7318429C6B5ADEF7318;
    localparam logic [127:0] RC_B_TBL  = 128'h14256731425673142567314256731425;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

    function automatic logic [3:0] get_nib(input logic [63:0] x, input int i);
        return x[63-4*i -: 4];
    endfunction

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        return SBOX_TBL[63-4*int'(n) -: 4];
    endfunction

    function automatic logic [63:0] sub_cells(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[63-4*i -: 4] = sbox4(get_nib(s, i));
        return o;
    endfunction

    // Gather permutation: out[i] = in[tbl[i]].
    function automatic logic [63:0] permute(input logic [63:0] s, input logic [63:0] tbl);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[63-4*i -: 4] = get_nib(s, int'(get_nib(tbl, i)));
        return o;
    endfunction

    function automatic logic [63:0] mix_columns(input logic [63:0] s);
        logic [63:0] o;
        o = s;
        for (int j = 0; j < 4; j++) begin
            o[63-4*j -: 4]     = get_nib(s, j) ^ get_nib(s, 8+j) ^ get_nib(s, 12+j);
            o[63-4*(4+j) -: 4] = get_nib(s, 4+j) ^ get_nib(s, 12+j);
        end
        return o;
    endfunction

    function automatic logic [3:0] rc_a(input logic [CNT_W-1:0] r);
        return RC_A_TBL[127-4*int'(r) -: 4];
    endfunction

    function automatic logic [2:0] rc_b(input logic [CNT_W-1:0] r);
        logic [3:0] t;
        t = RC_B_TBL[127-4*int'(r) -: 4];
        return t[2:0];
    endfunction
endpackage

// File: rtl/craft_dec_round.sv
// One combinational CRAFT inverse round. i_last undoes the final encryption
// round, which has no S-box/permutation layer.
module craft_dec_round
    import craft_pkg::*;
(
    input  logic [STATE_W-1:0] i_s,
    input  logic [TK_W-1:0]    i_tk,
    input  logic [3:0]         i_rc_a,
    input  logic [2:0]         i_rc_b,
    input  logic               i_last,
    output logic [STATE_W-1:0] o_s
);
    logic [STATE_W-1:0] w_unsub;
    logic [STATE_W-1:0] w_pre;
    logic [STATE_W-1:0] w_rc;
    logic [STATE_W-1:0] w_keyed;

    assign w_unsub = permute(sub_cells(i_s), PNINV_TBL);
    assign w_pre   = i_last ? i_s : w_unsub;
    assign w_rc    = {16'h0, i_rc_a, 1'b0, i_rc_b, 40'h0};
    assign w_keyed = w_pre ^ i_tk ^ w_rc;
    assign o_s     = mix_columns(w_keyed);
endmodule

// File: rtl/craft_decrypt.sv
// Iterative CRAFT decryption core: one inverse round per clock, 32 rounds,
// valid/ready on both sides.
module craft_decrypt
    import craft_pkg::*;
#(
    parameter int NR_ROUNDS = NR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [STATE_W-1:0]  ciphertext,
    input  logic [TK_W-1:0]     tweak,
    input  logic [KEY_W-1:0]    key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [STATE_W-1:0]  plaintext
);
    state_t             r_state;
    logic [1:0]         r_rst_sync;
    logic [CNT_W-1:0]   r_round;
    logic [STATE_W-1:0] r_s;
    logic [TK_W-1:0]    r_tk0, r_tk1, r_tk2, r_tk3;
    logic               r_out_valid;
    logic [STATE_W-1:0] r_plaintext;

    logic               w_in_ready;
    logic [TK_W-1:0]    w_tq;
    logic [TK_W-1:0]    w_tk_sel;
    logic [STATE_W-1:0] w_round_out;
    logic               w_last;

    // Reset asserts asynchronously; acceptance waits for a synchronised release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_in_ready = (r_state == ST_IDLE) && r_rst_sync[1];
    assign w_tq       = permute(tweak, Q_TBL);
    assign w_last     = (r_round == CNT_W'(NR_ROUNDS - 1));

    always_comb begin
        w_tk_sel = r_tk0;
        case (r_round[1:0])
            2'd0: w_tk_sel = r_tk0;
            2'd1: w_tk_sel = r_tk1;
            2'd2: w_tk_sel = r_tk2;
            2'd3: w_tk_sel = r_tk3;
            default: w_tk_sel = r_tk0;
        endcase
    end

    craft_dec_round u_round (
        .i_s    (r_s),
        .i_tk   (w_tk_sel),
        .i_rc_a (rc_a(r_round)),
        .i_rc_b (rc_b(r_round)),
        .i_last (w_last),
        .o_s    (w_round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_round     <= '0;
            r_s         <= '0;
            r_tk0       <= '0;
            r_tk1       <= '0;
            r_tk2       <= '0;
            r_tk3       <= '0;
            r_out_valid <= 1'b0;
            r_plaintext <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && w_in_ready) begin
                        r_s     <= ciphertext;
                        r_tk0   <= key[127:64] ^ tweak;
                        r_tk1   <= key[63:0]   ^ tweak;
                        r_tk2   <= key[127:64] ^ w_tq;
                        r_tk3   <= key[63:0]   ^ w_tq;
                        r_round <= CNT_W'(NR_ROUNDS - 1);
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_s <= w_round_out;
                    if (r_round == '0) begin
                        r_plaintext <= w_round_out;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_round <= r_round - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign plaintext = r_plaintext;
endmodule
